// File: rtl/chess_pkg.sv
// Shared codes for the chess datapath: pieces, colours, capture roles,
// move-ordering priorities and the arbiter iterator state encoding.
`timescale 1ns/1ps
package chess_pkg;

    typedef enum logic [2:0] {
        PAWN   = 3'd0,
        KNIGHT = 3'd1,
        BISHOP = 3'd2,
        ROOK   = 3'd3,
        QUEEN  = 3'd4,
        KING   = 3'd5,
        EMPTY  = 3'd7
    } piece_e;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } colour_e;

    typedef enum logic {
        VICTIM    = 1'b0,
        AGGRESSOR = 1'b1
    } role_e;

    localparam logic [2:0] PRIO_NONE          = 3'd0;
    localparam logic [2:0] PRIO_QUIET         = 3'd1;
    localparam logic [2:0] PRIO_PAWN_VICTIM   = 3'd2;
    localparam logic [2:0] PRIO_KNIGHT_VICTIM = 3'd3;
    localparam logic [2:0] PRIO_BISHOP_VICTIM = 3'd4;
    localparam logic [2:0] PRIO_ROOK_VICTIM   = 3'd5;
    localparam logic [2:0] PRIO_QUEEN_VICTIM  = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_max.sv
// Combinational max over GROUP (priority, index) pairs; the lowest
// position wins ties because a later entry replaces only on strictly greater.
`timescale 1ns/1ps
module arb_max #(
    parameter int unsigned GROUP  = 8,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned IDX_W  = 6
) (
    input  logic [GROUP*PRIO_W-1:0] prio_vec,
    input  logic [GROUP*IDX_W-1:0]  idx_vec,
    output logic [PRIO_W-1:0]       max_prio,
    output logic [IDX_W-1:0]        max_idx
);

    always_comb begin
        max_prio = prio_vec[0 +: PRIO_W];
        max_idx  = idx_vec[0 +: IDX_W];
        for (int unsigned i = 1; i < GROUP; i++) begin
            if (prio_vec[i*PRIO_W +: PRIO_W] > max_prio) begin
                max_prio = prio_vec[i*PRIO_W +: PRIO_W];
                max_idx  = idx_vec[i*IDX_W +: IDX_W];
            end
        end
    end

endmodule

// File: rtl/arb_iter.sv
// Sequential priority iterator: snapshots per-entry priorities and streams
// every non-zero entry in descending priority (lowest index on ties).
`timescale 1ns/1ps
module arb_iter
    import chess_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 64,
    parameter int unsigned PRIO_W    = 3,
    parameter int unsigned GROUP     = 8,
    parameter int unsigned PIPE      = 0,
    parameter int unsigned IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_ENTRIES*PRIO_W-1:0]   prio_in,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_index,
    output logic [PRIO_W-1:0]             out_prio,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W:0]                count
);

    localparam int unsigned N_GROUPS = N_ENTRIES / GROUP;

    arb_state_e state, state_d;
    logic                        fill_cnt, fill_cnt_d;
    logic                        load_out, take;
    logic [N_ENTRIES*PRIO_W-1:0] snapshot;
    logic [N_ENTRIES*PRIO_W-1:0] masked_prio;
    logic [N_ENTRIES-1:0]        mask, nz, cur_onehot;
    logic [N_GROUPS*PRIO_W-1:0]  grp_prio, grp_prio_q;
    logic [N_GROUPS*IDX_W-1:0]   grp_idx, grp_idx_q;
    logic [PRIO_W-1:0]           win_prio;
    logic [IDX_W-1:0]            win_idx;

    always_comb begin
        masked_prio = '0;
        nz          = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            masked_prio[i*PRIO_W +: PRIO_W] = mask[i] ? '0 : snapshot[i*PRIO_W +: PRIO_W];
            nz[i] = |masked_prio[i*PRIO_W +: PRIO_W];
        end
    end

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_group
        logic [GROUP*IDX_W-1:0] gidx;
        always_comb begin
            gidx = '0;
            for (int unsigned j = 0; j < GROUP; j++) begin
                gidx[j*IDX_W +: IDX_W] = IDX_W'(g*GROUP + j);
            end
        end
        arb_max #(.GROUP(GROUP), .PRIO_W(PRIO_W), .IDX_W(IDX_W)) u_grp (
            .prio_vec (masked_prio[g*GROUP*PRIO_W +: GROUP*PRIO_W]),
            .idx_vec  (gidx),
            .max_prio (grp_prio[g*PRIO_W +: PRIO_W]),
            .max_idx  (grp_idx[g*IDX_W +: IDX_W])
        );
    end

    if (PIPE != 0) begin : g_pipe
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                grp_prio_q <= '0;
                grp_idx_q  <= '0;
            end else begin
                grp_prio_q <= grp_prio;
                grp_idx_q  <= grp_idx;
            end
        end
    end else begin : g_nopipe
        assign grp_prio_q = grp_prio;
        assign grp_idx_q  = grp_idx;
    end

    arb_max #(.GROUP(N_GROUPS), .PRIO_W(PRIO_W), .IDX_W(IDX_W)) u_final (
        .prio_vec (grp_prio_q),
        .idx_vec  (grp_idx_q),
        .max_prio (win_prio),
        .max_idx  (win_idx)
    );

    // Last candidate: nothing unmasked remains once the presented entry is removed.
    assign cur_onehot = N_ENTRIES'(1) << out_index;
    assign out_last   = (state == PRESENT) && ((nz & ~cur_onehot) == '0);
    assign out_valid  = (state == PRESENT);
    assign busy       = (state == FILL) || (state == PRESENT);
    assign done       = (state == FINISH);

    always_comb begin
        state_d    = state;
        fill_cnt_d = 1'b0;
        load_out   = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: ;
            FILL: begin
                if (PIPE != 0 && !fill_cnt) begin
                    fill_cnt_d = 1'b1;
                end else if (win_prio != '0) begin
                    state_d  = PRESENT;
                    load_out = 1'b1;
                end else begin
                    state_d = FINISH;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    take    = 1'b1;
                    state_d = out_last ? FINISH : FILL;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && busy) begin
            state_d  = FINISH;
            load_out = 1'b0;
        end
        if (start) begin
            state_d    = FILL;
            fill_cnt_d = 1'b0;
            load_out   = 1'b0;
            take       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fill_cnt  <= 1'b0;
            snapshot  <= '0;
            mask      <= '0;
            count     <= '0;
            out_index <= '0;
            out_prio  <= '0;
        end else begin
            state    <= state_d;
            fill_cnt <= fill_cnt_d;
            if (start) begin
                snapshot <= prio_in;
                mask     <= '0;
                count    <= '0;
            end else if (take) begin
                mask[out_index] <= 1'b1;
                count           <= count + (IDX_W+1)'(1);
            end
            if (load_out) begin
                out_index <= win_idx;
                out_prio  <= win_prio;
            end
        end
    end

endmodule
